// File: rtl/ysyx_25040109_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040109_mem_arbiter
// Brief    : Two-master (IFU read, LSU read/write) to one-slave data memory
//            arbiter. Registers each accepted request and runs exactly one
//            downstream transaction at a time, routing the response back to
//            the granted master.
//            Optional macro ARB_RR_EN: round-robin between IFU and LSU
//            instead of fixed priority (LSU write > LSU read > IFU read).
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25040109_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,

    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [2:0]        lsu_wlen,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,
    output logic              lsu_bvalid,
    input  logic              lsu_bready,

    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_wlen,
    output logic              mem_wen,
    output logic              mem_wvalid,
    input  logic              mem_wready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_IRD   = 3'd1;
    localparam logic [2:0] S_DRD   = 3'd2;
    localparam logic [2:0] S_DWR   = 3'd3;
    localparam logic [2:0] S_DRESP = 3'd4;

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic              grant_ifu;
    logic              grant_drd;
    logic              grant_dwr;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [2:0]        lat_wlen;

`ifdef ARB_RR_EN
    // 0: IFU was granted last, 1: LSU (read or write) was granted last
    logic              last_lsu;

    // Record the last granted master, only on an accepted handshake
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_lsu <= 1'b0;
        end else if (grant_ifu) begin
            last_lsu <= 1'b0;
        end else if (grant_drd || grant_dwr) begin
            last_lsu <= 1'b1;
        end
    end
`endif

    // Pick at most one winner in IDLE; grants are suppressed while in reset
    // so nothing is accepted that the reset would immediately discard.
    always_comb begin
        grant_ifu = 1'b0;
        grant_drd = 1'b0;
        grant_dwr = 1'b0;
        if (rst && (state == S_IDLE)) begin
`ifdef ARB_RR_EN
            if (ifu_arvalid && (last_lsu || !(lsu_wvalid || lsu_arvalid))) begin
                grant_ifu = 1'b1;
            end else if (lsu_wvalid) begin
                grant_dwr = 1'b1;
            end else if (lsu_arvalid) begin
                grant_drd = 1'b1;
            end
`else
            if (lsu_wvalid) begin
                grant_dwr = 1'b1;
            end else if (lsu_arvalid) begin
                grant_drd = 1'b1;
            end else if (ifu_arvalid) begin
                grant_ifu = 1'b1;
            end
`endif
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (grant_dwr) begin
                    next_state = S_DWR;
                end else if (grant_drd) begin
                    next_state = S_DRD;
                end else if (grant_ifu) begin
                    next_state = S_IRD;
                end
            end
            S_IRD: begin
                if (mem_rvalid && ifu_rready) begin
                    next_state = S_IDLE;
                end
            end
            S_DRD: begin
                if (mem_rvalid && lsu_rready) begin
                    next_state = S_IDLE;
                end
            end
            S_DWR: begin
                if (mem_wready) begin
                    next_state = S_DRESP;
                end
            end
            S_DRESP: begin
                if (lsu_bready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Capture the winning request; registers change only on an IDLE handshake
    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wlen  <= 3'b000;
        end else if (grant_dwr) begin
            lat_addr  <= lsu_awaddr;
            lat_wdata <= lsu_wdata;
            lat_wlen  <= lsu_wlen;
        end else if (grant_drd) begin
            lat_addr  <= lsu_araddr;
        end else if (grant_ifu) begin
            lat_addr  <= ifu_araddr;
        end
    end

    // Output decode: handshakes, downstream request and response routing
    always_comb begin
        ifu_arready = grant_ifu;
        lsu_arready = grant_drd;
        lsu_wready  = grant_dwr;
        ifu_rdata   = '0;
        ifu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rvalid  = 1'b0;
        lsu_bvalid  = 1'b0;
        mem_raddr   = lat_addr;
        mem_ren     = 1'b0;
        mem_rready  = 1'b0;
        mem_waddr   = lat_addr;
        mem_wdata   = lat_wdata;
        mem_wlen    = lat_wlen;
        mem_wen     = 1'b0;
        mem_wvalid  = 1'b0;
        case (state)
            S_IRD: begin
                // Request stays up until the data shows; then stop asking
                mem_ren    = !mem_rvalid;
                ifu_rvalid = mem_rvalid;
                ifu_rdata  = mem_rdata;
                mem_rready = ifu_rready;
            end
            S_DRD: begin
                mem_ren    = !mem_rvalid;
                lsu_rvalid = mem_rvalid;
                lsu_rdata  = mem_rdata;
                mem_rready = lsu_rready;
            end
            S_DWR: begin
                mem_wvalid = 1'b1;
                mem_wen    = 1'b1;
            end
            S_DRESP: begin
                lsu_bvalid = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040109_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25040109_mem_arbiter
// Brief    : Directed self-checking bench for the IFU/LSU memory arbiter,
//            with a small behavioural memory (3-cycle read, byte-lane writes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040109_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [31:0] ifu_araddr = '0;
    logic        ifu_arvalid = 1'b0;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic        ifu_rvalid;
    logic        ifu_rready = 1'b0;
    logic [31:0] lsu_araddr = '0;
    logic        lsu_arvalid = 1'b0;
    logic        lsu_arready;
    logic [31:0] lsu_rdata;
    logic        lsu_rvalid;
    logic        lsu_rready = 1'b0;
    logic [31:0] lsu_awaddr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [2:0]  lsu_wlen = '0;
    logic        lsu_wvalid = 1'b0;
    logic        lsu_wready;
    logic        lsu_bvalid;
    logic        lsu_bready = 1'b0;
    logic [31:0] mem_raddr;
    logic        mem_ren;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_wlen;
    logic        mem_wen;
    logic        mem_wvalid;
    logic        mem_wready = 1'b1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ysyx_25040109_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_wdata(lsu_wdata), .lsu_wlen(lsu_wlen),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .mem_raddr(mem_raddr), .mem_ren(mem_ren),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wlen(mem_wlen),
        .mem_wen(mem_wen), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready)
    );

    // Memory model: word array, read data appears after three cycles of ren
    logic [31:0] mem [0:4095];
    logic [1:0]  rd_cnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        preload = 1'b1;
    int          nbytes;

    assign mem_rvalid = m_rvalid;
    assign mem_rdata  = m_rdata;

    always @(posedge clk) begin
        if (preload) begin
            mem[12'h000] <= 32'h0000_0413;
            mem[12'h400] <= 32'hDEAD_BEEF;
        end
        if (!rst) begin
            rd_cnt   <= 2'd0;
            m_rvalid <= 1'b0;
            m_rdata  <= '0;
        end else begin
            if (m_rvalid) begin
                if (mem_rready) begin
                    m_rvalid <= 1'b0;
                    rd_cnt   <= 2'd0;
                end
            end else if (mem_ren) begin
                if (rd_cnt == 2'd2) begin
                    m_rvalid <= 1'b1;
                    m_rdata  <= mem[mem_raddr[13:2]];
                    rd_cnt   <= 2'd0;
                end else begin
                    rd_cnt <= rd_cnt + 2'd1;
                end
            end else begin
                rd_cnt <= 2'd0;
            end
            if (mem_wvalid && mem_wready) begin
                nbytes = (mem_wlen == 3'b001) ? 1 : (mem_wlen == 3'b010) ? 2 :
                         (mem_wlen == 3'b100) ? 4 : 0;
                for (int i = 0; i < 4; i++) begin
                    if (i < nbytes) begin
                        mem[mem_waddr[13:2]][8*((int'(mem_waddr[1:0]) + i) % 4) +: 8]
                            <= mem_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the chosen master's rvalid, then check the data
    task automatic wait_read(input bit is_lsu, input logic [31:0] exp, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if ((is_lsu ? lsu_rvalid : ifu_rvalid) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, " rvalid seen"}, {31'd0, seen}, 32'd1);
        chk({tag, " rdata"}, is_lsu ? lsu_rdata : ifu_rdata, exp);
        chk({tag, " other rvalid"}, {31'd0, is_lsu ? ifu_rvalid : lsu_rvalid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [2:0] exp_lsu;
`ifdef ARB_RR_EN
        exp_lsu = 3'b101;
`else
        exp_lsu = 3'b111;
`endif
        // Reset with every request raised: nothing may be accepted
        repeat (2) @(posedge clk);
        #1;
        preload     = 1'b0;
        ifu_arvalid = 1'b1;
        lsu_arvalid = 1'b1;
        lsu_wvalid  = 1'b1;
        #1;
        chk("rst ifu_arready", {31'd0, ifu_arready}, 32'd0);
        chk("rst lsu_arready", {31'd0, lsu_arready}, 32'd0);
        chk("rst lsu_wready", {31'd0, lsu_wready}, 32'd0);
        chk("rst mem_ren", {31'd0, mem_ren}, 32'd0);
        chk("rst mem_wvalid", {31'd0, mem_wvalid}, 32'd0);
        chk("rst lsu_bvalid", {31'd0, lsu_bvalid}, 32'd0);
        chk("rst mem_raddr", mem_raddr, 32'd0);
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;
        lsu_wvalid  = 1'b0;
        rst         = 1'b1;
        ifu_rready  = 1'b1;
        lsu_rready  = 1'b1;
        lsu_bready  = 1'b1;
        tick();

        // IFU-only fetch, exact cycle timing
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0000;
        #1;
        chk("ifu c0 arready", {31'd0, ifu_arready}, 32'd1);
        chk("ifu c0 lsu_arready", {31'd0, lsu_arready}, 32'd0);
        tick();
        ifu_arvalid = 1'b0;
        #1;
        chk("ifu c1 mem_ren", {31'd0, mem_ren}, 32'd1);
        chk("ifu c1 mem_raddr", mem_raddr, 32'h8000_0000);
        chk("ifu c1 rvalid", {31'd0, ifu_rvalid}, 32'd0);
        tick();
        chk("ifu c2 mem_ren", {31'd0, mem_ren}, 32'd1);
        tick();
        chk("ifu c3 mem_ren", {31'd0, mem_ren}, 32'd1);
        chk("ifu c3 rvalid", {31'd0, ifu_rvalid}, 32'd0);
        tick();
        chk("ifu c4 rvalid", {31'd0, ifu_rvalid}, 32'd1);
        chk("ifu c4 rdata", ifu_rdata, 32'h0000_0413);
        chk("ifu c4 mem_ren", {31'd0, mem_ren}, 32'd0);
        chk("ifu c4 mem_rready", {31'd0, mem_rready}, 32'd1);
        chk("ifu c4 lsu_rvalid", {31'd0, lsu_rvalid}, 32'd0);
        tick();
        chk("ifu c5 rvalid", {31'd0, ifu_rvalid}, 32'd0);
        chk("ifu c5 mem_rready", {31'd0, mem_rready}, 32'd0);

        // Both masters requesting every cycle
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0000;
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h8000_1000;
        for (int g = 0; g < 3; g++) begin
            #1;
            chk("sim lsu_arready", {31'd0, lsu_arready}, {31'd0, exp_lsu[g]});
            chk("sim ifu_arready", {31'd0, ifu_arready}, {31'd0, ~exp_lsu[g]});
            chk("sim double grant", {31'd0, ifu_arready & lsu_arready}, 32'd0);
            tick();
            chk("sim busy readies", {30'd0, ifu_arready, lsu_arready}, 32'd0);
            wait_read(exp_lsu[g], exp_lsu[g] ? 32'hDEAD_BEEF : 32'h0000_0413, "sim");
            tick();
        end
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;
        #1;

        // Store byte, racing an LSU read: write must win
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h8000_1000;
        lsu_wvalid  = 1'b1;
        lsu_awaddr  = 32'h8000_0003;
        lsu_wdata   = 32'h0000_00AB;
        lsu_wlen    = 3'b001;
        #1;
        chk("st c0 wready", {31'd0, lsu_wready}, 32'd1);
        chk("st c0 arready", {31'd0, lsu_arready}, 32'd0);
        chk("st c0 ifu_arready", {31'd0, ifu_arready}, 32'd0);
        tick();
        lsu_wvalid  = 1'b0;
        lsu_arvalid = 1'b0;
        lsu_wdata   = 32'hFFFF_FFFF;
        #1;
        chk("st c1 mem_wvalid", {31'd0, mem_wvalid}, 32'd1);
        chk("st c1 mem_wen", {31'd0, mem_wen}, 32'd1);
        chk("st c1 mem_waddr", mem_waddr, 32'h8000_0003);
        chk("st c1 mem_wdata", mem_wdata, 32'h0000_00AB);
        chk("st c1 mem_wlen", {29'd0, mem_wlen}, 32'd1);
        chk("st c1 bvalid", {31'd0, lsu_bvalid}, 32'd0);
        tick();
        chk("st c2 bvalid", {31'd0, lsu_bvalid}, 32'd1);
        chk("st c2 mem_wvalid", {31'd0, mem_wvalid}, 32'd0);
        tick();
        chk("st c3 bvalid", {31'd0, lsu_bvalid}, 32'd0);
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h8000_0000;
        #1;
        chk("rb arready", {31'd0, lsu_arready}, 32'd1);
        tick();
        lsu_arvalid = 1'b0;
        #1;
        wait_read(1'b1, 32'hAB00_0413, "readback");
        tick();

        // Backpressure on the LSU response with IFU waiting
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h8000_1000;
        lsu_rready  = 1'b0;
        #1;
        chk("bp arready", {31'd0, lsu_arready}, 32'd1);
        tick();
        lsu_arvalid = 1'b0;
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0000;
        #1;
        wait_read(1'b1, 32'hDEAD_BEEF, "bp");
        for (int k = 0; k < 5; k++) begin
            chk("bp stall rvalid", {31'd0, lsu_rvalid}, 32'd1);
            chk("bp stall rdata", lsu_rdata, 32'hDEAD_BEEF);
            chk("bp stall mem_rready", {31'd0, mem_rready}, 32'd0);
            chk("bp stall ifu_arready", {31'd0, ifu_arready}, 32'd0);
            tick();
        end
        lsu_rready = 1'b1;
        #1;
        chk("bp release mem_rready", {31'd0, mem_rready}, 32'd1);
        chk("bp release rvalid", {31'd0, lsu_rvalid}, 32'd1);
        tick();
        chk("bp ifu granted", {31'd0, ifu_arready}, 32'd1);
        tick();
        ifu_arvalid = 1'b0;
        #1;
        wait_read(1'b0, 32'hAB00_0413, "bp ifu");
        tick();

        // Reset while in DRD
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h8000_1000;
        #1;
        chk("rd c0 arready", {31'd0, lsu_arready}, 32'd1);
        tick();
        lsu_arvalid = 1'b0;
        #1;
        chk("rd c1 mem_ren", {31'd0, mem_ren}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rd c3 mem_ren", {31'd0, mem_ren}, 32'd0);
        chk("rd c3 mem_rready", {31'd0, mem_rready}, 32'd0);
        chk("rd c3 lsu_rvalid", {31'd0, lsu_rvalid}, 32'd0);
        chk("rd c3 ifu_rvalid", {31'd0, ifu_rvalid}, 32'd0);
        chk("rd c3 lsu_rdata", lsu_rdata, 32'd0);
        chk("rd c3 mem_raddr", mem_raddr, 32'd0);
        chk("rd c3 mem_wvalid", {31'd0, mem_wvalid}, 32'd0);
        chk("rd c3 bvalid", {31'd0, lsu_bvalid}, 32'd0);
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0000;
        #1;
        chk("rd ifu arready", {31'd0, ifu_arready}, 32'd1);
        tick();
        ifu_arvalid = 1'b0;
        #1;
        wait_read(1'b0, 32'hAB00_0413, "post-reset ifu");
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
